// File: rtl/fetch_stage_controller_pkg.sv
// Shared fetch-stage constants: FSM state encodings, the bubble instruction
// and the PC increment used by the fetch controller and its IF/ID register.
package fetch_stage_controller_pkg;

    typedef enum logic [1:0] {
        FETCH_RUN     = 2'd0,
        FETCH_STALL   = 2'd1,
        FETCH_FLUSHED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INCR   = 32'd4;

endpackage

// File: rtl/fetch_stage_controller_if_id_register.sv
// IF/ID pipeline register: {instr, pc_plus4, valid}. A load with bubble set
// replaces the fetched instruction with a nop and marks the slot invalid.
module if_id_register
    import fetch_stage_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr    <= '0;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            instr    <= bubble ? NOP_INSTR : instr_in;
            pc_plus4 <= pc_plus4_in;
            valid    <= ~bubble;
        end
    end

endmodule

// File: rtl/fetch_stage_controller.sv
// Fetch-stage controller: PC register, IF/ID register, stall/flush FSM and
// stall-length monitor. Optional statistics counters under FETCH_STATS_EN.
module fetch_stage_controller
    import fetch_stage_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MAX_STALL = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        IF_ID_write,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_pc_plus4,
    output logic        IF_ID_valid,
    output logic [1:0]  fetch_state,
    output logic        stall_overrun
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    localparam logic [3:0] STALL_LIMIT = 4'(MAX_STALL);

    logic         adv;
    logic         take_flush;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  pc_plus4;
    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [2:0]   stall_cnt_q;
    logic [2:0]   stall_cnt_d;
    logic [3:0]   stall_cnt_inc;
    logic         overrun_d;

    assign adv        = pc_write & IF_ID_write;
    // A flush seen while stalled is not final yet; the hazard unit repeats it.
    assign take_flush = adv & flush;
    assign pc_plus4   = pc_q + PC_INCR;

    always_comb begin
        pc_d = pc_q;
        if (pc_write) begin
            pc_d = take_flush ? redirect_pc : pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_comb begin
        state_d = FETCH_RUN;
        if (!adv) begin
            state_d = FETCH_STALL;
        end else if (flush) begin
            state_d = FETCH_FLUSHED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign stall_cnt_inc = {1'b0, stall_cnt_q} + 4'd1;

    // Overrun is judged on the unsaturated increment so it still fires at the cap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        overrun_d   = stall_overrun;
        if (adv) begin
            stall_cnt_d = '0;
        end else begin
            if (stall_cnt_inc > STALL_LIMIT) begin
                overrun_d = 1'b1;
            end
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_inc[2:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q   <= '0;
            stall_overrun <= 1'b0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            stall_overrun <= overrun_d;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!adv && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (take_flush && flush_count != '1) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

    if_id_register u_if_id (
        .clk         (clk),
        .rst         (rst),
        .load        (IF_ID_write),
        .bubble      (take_flush),
        .instr_in    (imem_rdata),
        .pc_plus4_in (pc_plus4),
        .instr       (IF_ID_instr),
        .pc_plus4    (IF_ID_pc_plus4),
        .valid       (IF_ID_valid)
    );

    assign imem_addr   = pc_q;
    assign fetch_state = state_q;

endmodule

// File: tb/tb_fetch_stage_controller.sv
// Directed bench for fetch_stage_controller with a cycle-level reference model.
module tb_fetch_stage_controller;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int unsigned MAXS   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write, IF_ID_write, flush;
    logic [31:0] redirect_pc, imem_rdata, imem_addr;
    logic [31:0] IF_ID_instr, IF_ID_pc_plus4;
    logic        IF_ID_valid, stall_overrun;
    logic [1:0]  fetch_state;
`ifdef FETCH_STATS_EN
    logic [15:0] stall_cycles, flush_count;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid, m_ovr;
    int          m_state, m_run;
    int          m_stalls, m_flushes;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a + 32'h2000_0001;
    endfunction

    assign imem_rdata = mem(imem_addr);

    fetch_stage_controller #(.RESET_PC(RST_PC), .MAX_STALL(MAXS)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_write       (pc_write),
        .IF_ID_write    (IF_ID_write),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .imem_rdata     (imem_rdata),
        .imem_addr      (imem_addr),
        .IF_ID_instr    (IF_ID_instr),
        .IF_ID_pc_plus4 (IF_ID_pc_plus4),
        .IF_ID_valid    (IF_ID_valid),
        .fetch_state    (fetch_state),
        .stall_overrun  (stall_overrun)
`ifdef FETCH_STATS_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_pc = RST_PC; m_instr = 0; m_pp4 = 0; m_valid = 0; m_ovr = 0;
        m_state = 0; m_run = 0; m_stalls = 0; m_flushes = 0;
    endtask

    task automatic model_edge(input logic pw, input logic iw, input logic fl, input logic [31:0] rp);
        bit          go;
        logic [31:0] next_seq;
        go = pw && iw;
        next_seq = m_pc + 32'd4;
        if (iw) begin
            m_pp4   = next_seq;
            m_valid = !(go && fl);
            m_instr = (go && fl) ? 32'h0 : mem(m_pc);
        end
        if (pw) m_pc = (go && fl) ? rp : next_seq;
        m_state = !go ? 1 : (fl ? 2 : 0);
        if (go) begin
            m_run = 0;
            if (fl && m_flushes < 65535) m_flushes++;
        end else begin
            if (m_run + 1 > MAXS) m_ovr = 1;
            if (m_run < 7) m_run++;
            if (m_stalls < 65535) m_stalls++;
        end
    endtask

    task automatic step(input logic pw, input logic iw, input logic fl, input logic [31:0] rp);
        pc_write = pw; IF_ID_write = iw; flush = fl; redirect_pc = rp;
        @(posedge clk);
        model_edge(pw, iw, fl, rp);
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("IF_ID_instr", IF_ID_instr, m_instr);
            chk("IF_ID_pc_plus4", IF_ID_pc_plus4, m_pp4);
            chk("IF_ID_valid", 32'(IF_ID_valid), 32'(m_valid));
            chk("fetch_state", 32'(fetch_state), 32'(m_state));
            chk("stall_overrun", 32'(stall_overrun), 32'(m_ovr));
`ifdef FETCH_STATS_EN
            chk("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
            chk("flush_count", 32'(flush_count), 32'(m_flushes));
`endif
        end
    end

    initial begin
        rst = 1'b1;
        pc_write = 1'b1; IF_ID_write = 1'b1; flush = 1'b0; redirect_pc = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", imem_addr, 32'h100);
        chk("rst_instr", IF_ID_instr, 32'h0);
        chk("rst_pp4", IF_ID_pc_plus4, 32'h0);
        chk("rst_valid", 32'(IF_ID_valid), 32'h0);
        chk("rst_state", 32'(fetch_state), 32'h0);
        chk("rst_ovr", 32'(stall_overrun), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;

        step(1, 1, 0, 0);
        chk("run1_addr", imem_addr, 32'h104);
        chk("run1_pp4", IF_ID_pc_plus4, 32'h104);
        step(1, 1, 0, 0);
        chk("run2_addr", imem_addr, 32'h108);
        step(0, 0, 0, 0);
        chk("stall_addr", imem_addr, 32'h108);
        chk("stall_pp4", IF_ID_pc_plus4, 32'h108);
        chk("stall_state", 32'(fetch_state), 32'd1);
        step(1, 1, 0, 0);
        chk("resume_addr", imem_addr, 32'h10C);
        chk("resume_state", 32'(fetch_state), 32'd0);
        step(1, 1, 1, 32'h200);
        chk("flush_addr", imem_addr, 32'h200);
        chk("flush_valid", 32'(IF_ID_valid), 32'h0);
        chk("flush_instr", IF_ID_instr, 32'h0);
        chk("flush_pp4", IF_ID_pc_plus4, 32'h110);
        chk("flush_state", 32'(fetch_state), 32'd2);
        step(1, 1, 0, 0);
        chk("post_flush_addr", imem_addr, 32'h204);
        chk("post_flush_instr", IF_ID_instr, 32'h2000_0201);
        chk("post_flush_valid", 32'(IF_ID_valid), 32'h1);
        step(0, 1, 1, 32'h300);
        chk("ign_flush_addr", imem_addr, 32'h204);
        chk("ign_flush_valid", 32'(IF_ID_valid), 32'h1);
        step(1, 0, 1, 32'h300);
        chk("ign_flush2_addr", imem_addr, 32'h208);
        step(1, 1, 1, 32'hFFFF_FFFC);
        step(1, 1, 0, 0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pp4", IF_ID_pc_plus4, 32'h0);
        step(1, 1, 1, 32'h300);
        step(1, 1, 1, 32'h400);
        chk("b2b_addr", imem_addr, 32'h400);
        chk("b2b_state", 32'(fetch_state), 32'd2);
        step(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            if (i == 2) chk("ovr_at3", 32'(stall_overrun), 32'h0);
        end
        chk("ovr_at4", 32'(stall_overrun), 32'h1);
        step(1, 1, 0, 0);
        chk("ovr_sticky", 32'(stall_overrun), 32'h1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        chk("mid_rst_ovr", 32'(stall_overrun), 32'h0);
        chk("mid_rst_addr", imem_addr, 32'h100);
        chk("mid_rst_valid", 32'(IF_ID_valid), 32'h0);
        chk("mid_rst_state", 32'(fetch_state), 32'h0);
`ifdef FETCH_STATS_EN
        chk("mid_rst_stalls", 32'(stall_cycles), 32'h0);
        chk("mid_rst_flushes", 32'(flush_count), 32'h0);
`endif
        pc_write = 1'b1; IF_ID_write = 1'b1; flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1, 1, 0, 0);
        chk("first_fetch_pp4", IF_ID_pc_plus4, 32'h104);
        chk("first_fetch_addr", imem_addr, 32'h104);
        step(1, 1, 0, 0);
        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage_controller.md
# fetch_stage_controller

Fetch-side consumer of the data-hazard detection unit's control outputs in the five-stage MIPS pipeline. It owns the PC register and the IF/ID pipeline register. It applies the `pc_write`, `IF_ID_write` and `flush` commands cycle by cycle. It redirects fetch to the branch/jump target on a flush and inserts a bubble into IF/ID. It also tracks stall episodes with a small state machine and a bounded stall-length monitor.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `MAX_STALL`, 3, longest legal run of consecutive stall cycles before `stall_overrun` is raised.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `pc_write`  in  1  1 = PC may advance; 0 = hold PC.
- `IF_ID_write`  in  1  1 = IF/ID may load; 0 = hold IF/ID.
- `flush`  in  1  taken branch/jump resolved in ID; redirect and bubble.
- `redirect_pc`  in  32  branch/jump target, valid when `flush`=1.
- `imem_rdata`  in  32  instruction at `imem_addr`; combinational memory.
- `imem_addr`  out  32  current PC.
- `IF_ID_instr`  out  32  registered instruction (32'h0 = bubble/nop).
- `IF_ID_pc_plus4`  out  32  registered PC+4 of that instruction.
- `IF_ID_valid`  out  1  0 = bubble.
- `fetch_state`  out  2  current FSM state (debug).
- `stall_overrun`  out  1  sticky; stall run exceeded `MAX_STALL`.

## Operation
- Advance condition `adv` = `pc_write` & `IF_ID_write`.
- `flush` takes effect only when `adv`=1. It is ignored while stalled, because the ID branch outcome is not yet final and the hazard unit re-asserts it.
- `adv`=1 and `flush`=0: PC <= PC+4; IF/ID <= {`imem_rdata`, PC+4, valid=1}.
- `adv`=1 and `flush`=1: PC <= `redirect_pc`; IF/ID <= {32'h0, PC+4, valid=0}. The wrong-path fetch is discarded.
- `pc_write` and `IF_ID_write` otherwise act independently. `pc_write`=0 holds the PC. `IF_ID_write`=0 holds all IF/ID fields.
- PC+4 wraps modulo 2^32; 32'hFFFF_FFFC advances to 32'h0. `redirect_pc` is used unmodified; its low two bits are not checked.
- FSM states:
  - RUN=2'd0: normal operation.
  - STALL=2'd1: entered from any state when `adv`=0.
  - FLUSHED=2'd2: entered when `adv`=1 and `flush`=1; lasts one cycle while the bubble sits in IF/ID.
- FSM transitions:
  - Next state is STALL whenever `adv`=0.
  - Next state is FLUSHED on `adv`=1 with `flush`=1, from any state. Back-to-back flushes stay in FLUSHED.
  - Next state is RUN otherwise.
- Stall counter: 3-bit saturating count of consecutive STALL cycles. It clears to 0 on any cycle with `adv`=1.
- `stall_overrun` sets when the counter would exceed `MAX_STALL`. It clears only on `rst`.

## Timing
- Reset values: PC=`RESET_PC`, `imem_addr`=`RESET_PC`, `IF_ID_instr`=0, `IF_ID_pc_plus4`=0, `IF_ID_valid`=0, `fetch_state`=RUN, stall counter=0, `stall_overrun`=0. Counters below also reset to 0.
- Reset is asynchronous. Asserting it mid-stall or mid-flush clears everything immediately. The first fetch is at `RESET_PC` on the first edge after deassertion.
- All control inputs are sampled on the rising `clk` edge and produce a one-cycle latency to the IF/ID outputs.
- `imem_addr` is driven directly from the PC register, with no combinational path from inputs.
- A load-use stall asserted for N cycles holds IF/ID and PC for exactly N edges.

## Configuration
- `FETCH_STATS_EN` defined:
  - adds outputs `stall_cycles` (16-bit) and `flush_count` (16-bit);
  - `stall_cycles` increments on each `adv`=0 cycle;
  - `flush_count` increments on each accepted flush;
  - both saturate at 16'hFFFF and reset to 0.
- `FETCH_STATS_EN` undefined: these ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package/header (alongside the existing constant values file):
  - FSM state encodings `FETCH_RUN`, `FETCH_STALL`, `FETCH_FLUSHED`;
  - `NOP_INSTR` = 32'h0;
  - `PC_INCR` = 4.
- One natural sub-module, `if_id_register`: holds {instr, pc_plus4, valid} and takes inputs `load` and `bubble`. PC, FSM and stall monitor stay in the top.

## Test plan
- Reset with `RESET_PC`=32'h100, no hazards for 3 cycles -> `imem_addr` 100, 104, 108, 10C. IF/ID pc_plus4 follows one cycle behind: 104, 108, 10C.
- `pc_write`=`IF_ID_write`=0 for 1 cycle at PC 32'h108 -> PC stays 108, IF/ID unchanged, `fetch_state`=STALL, then RUN.
- `flush`=1, `redirect_pc`=32'h200 at PC 32'h10C -> next PC 200, `IF_ID_valid`=0, `IF_ID_instr`=0, state FLUSHED. The following cycle fetches 200 with valid=1.
- `flush`=1 together with `pc_write`=0 -> flush ignored; PC held and no redirect occurs.
- Stall held 4 cycles with `MAX_STALL`=3 -> `stall_overrun` rises on the 4th stall edge and stays 1 until `rst`.
- Assert `rst` mid-stall; check `stall_overrun`=0, PC=`RESET_PC`, `IF_ID_valid`=0. With `FETCH_STATS_EN`, check `stall_cycles` and `flush_count` return to 0.
